// File: rtl/sc_ir_sequencer_pkg.sv
// sc_ir_sequencer_pkg: state, opcode-class and mux-select encodings for the ARC IR sequencer
package sc_ir_sequencer_pkg;
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_EXEC   = 3'd3,
    ST_MEM    = 3'd4,
    ST_WB     = 3'd5,
    ST_HALT   = 3'd6
  } state_t;
  typedef enum logic [2:0] {
    CLS_CALL, CLS_BRANCH, CLS_SETHI, CLS_ARITH, CLS_JMPL, CLS_LD, CLS_ST, CLS_ILL
  } cls_t;
  localparam logic [1:0] OP_BR   = 2'b00;
  localparam logic [1:0] OP_CALL = 2'b01;
  localparam logic [1:0] OP_ALU  = 2'b10;
  localparam logic [1:0] OP_MEM  = 2'b11;
  localparam logic [2:0] OP2_BRANCH = 3'b010;
  localparam logic [2:0] OP2_SETHI  = 3'b100;
  localparam logic [5:0] OP3_ADD   = 6'b000000;
  localparam logic [5:0] OP3_ADDCC = 6'b010000;
  localparam logic [5:0] OP3_ANDCC = 6'b010001;
  localparam logic [5:0] OP3_ORCC  = 6'b010010;
  localparam logic [5:0] OP3_ORNCC = 6'b010110;
  localparam logic [5:0] OP3_SRL   = 6'b100110;
  localparam logic [5:0] OP3_JMPL  = 6'b111000;
  localparam logic [5:0] OP3_LD    = 6'b000000;
  localparam logic [5:0] OP3_ST    = 6'b000100;
  localparam logic [1:0] PCSEL_PC4  = 2'b00;
  localparam logic [1:0] PCSEL_BR   = 2'b01;
  localparam logic [1:0] PCSEL_CALL = 2'b10;
  localparam logic [1:0] PCSEL_ALU  = 2'b11;
  localparam logic [1:0] WBSEL_ALU = 2'b00;
  localparam logic [1:0] WBSEL_MEM = 2'b01;
  localparam logic [1:0] WBSEL_PC  = 2'b10;
endpackage

// File: rtl/sc_ir_opdecode.sv
// sc_ir_opdecode: combinational instruction-class decode of {op, IR[24:19]}
module sc_ir_opdecode
  import sc_ir_sequencer_pkg::*;
(
  input  logic [7:0] op_bus,
  output cls_t       cls
);
  logic [1:0] op;
  logic [2:0] op2;
  logic [5:0] op3;
  logic       is_alu;
  assign op  = op_bus[7:6];
  assign op2 = op_bus[5:3];
  assign op3 = op_bus[5:0];
  assign is_alu = op3 inside {OP3_ADD, OP3_ADDCC, OP3_ANDCC, OP3_ORCC, OP3_ORNCC, OP3_SRL};
  always_comb begin
    cls = CLS_ILL;
    case (op)
      OP_CALL: cls = CLS_CALL;
      OP_BR:   cls = op2 == OP2_BRANCH ? CLS_BRANCH : op2 == OP2_SETHI ? CLS_SETHI : CLS_ILL;
      OP_ALU:  cls = op3 == OP3_JMPL ? CLS_JMPL : is_alu ? CLS_ARITH : CLS_ILL;
      OP_MEM:  cls = op3 == OP3_LD ? CLS_LD : op3 == OP3_ST ? CLS_ST : CLS_ILL;
      default: cls = CLS_ILL;
    endcase
  end
endmodule

// File: rtl/sc_ir_sequencer.sv
// sc_ir_sequencer: ARC fetch/decode/exec/mem/wb control FSM; SC_IRSEQ_TRAP_EN halts on illegal opcodes
module sc_ir_sequencer
  import sc_ir_sequencer_pkg::*;
#(
  parameter int COUNTWIDTH = 16
) (
  input  logic                  SC_IRSEQ_CLOCK_50,
  input  logic                  SC_IRSEQ_RESET_InLow,
  input  logic                  SC_IRSEQ_Start_In,
  input  logic [7:0]            SC_IRSEQ_OP_In,
  input  logic                  SC_IRSEQ_IR13_In,
  input  logic                  SC_IRSEQ_CondTrue_In,
  input  logic                  SC_IRSEQ_MemAck_In,
  output logic                  SC_IRSEQ_MemRead_Out,
  output logic                  SC_IRSEQ_MemWrite_Out,
  output logic                  SC_IRSEQ_IRWrite_OutLow,
  output logic                  SC_IRSEQ_PCWrite_OutLow,
  output logic [1:0]            SC_IRSEQ_PCSel_Out,
  output logic                  SC_IRSEQ_RegWrite_OutLow,
  output logic [1:0]            SC_IRSEQ_WBSel_Out,
  output logic                  SC_IRSEQ_ALUSrcImm_Out,
  output logic [2:0]            SC_IRSEQ_State_Out,
  output logic                  SC_IRSEQ_Error_Out,
  output logic [COUNTWIDTH-1:0] SC_IRSEQ_InstrCount_Out
);
  state_t                state, state_nx;
  cls_t                  cls_dec, cls;
  logic                  retire;
  logic [COUNTWIDTH-1:0] count;
  sc_ir_opdecode u_dec (
    .op_bus(SC_IRSEQ_OP_In),
    .cls   (cls_dec)
  );
  // class is latched on leaving DECODE so later strobes never see a changing IR
  always_ff @(posedge SC_IRSEQ_CLOCK_50 or negedge SC_IRSEQ_RESET_InLow)
    if (!SC_IRSEQ_RESET_InLow) begin
      state <= ST_IDLE;
      cls   <= CLS_ILL;
      count <= '0;
    end else begin
      state <= state_nx;
      if (state == ST_DECODE) cls <= cls_dec;
      if (retire) count <= count + COUNTWIDTH'(1);
    end
  always_comb begin
    state_nx                 = state;
    retire                   = 1'b0;
    SC_IRSEQ_MemRead_Out     = 1'b0;
    SC_IRSEQ_MemWrite_Out    = 1'b0;
    SC_IRSEQ_IRWrite_OutLow  = 1'b1;
    SC_IRSEQ_PCWrite_OutLow  = 1'b1;
    SC_IRSEQ_PCSel_Out       = PCSEL_PC4;
    SC_IRSEQ_RegWrite_OutLow = 1'b1;
    SC_IRSEQ_WBSel_Out       = WBSEL_ALU;
    SC_IRSEQ_ALUSrcImm_Out   = 1'b0;
    case (state)
      ST_IDLE: state_nx = SC_IRSEQ_Start_In ? ST_FETCH : ST_IDLE;
      ST_FETCH: begin
        SC_IRSEQ_MemRead_Out    = 1'b1;
        SC_IRSEQ_IRWrite_OutLow = !SC_IRSEQ_MemAck_In;
        state_nx                = SC_IRSEQ_MemAck_In ? ST_DECODE : ST_FETCH;
      end
      ST_DECODE: begin
        if (cls_dec == CLS_CALL) state_nx = ST_WB;
        else if (cls_dec == CLS_ILL)
`ifdef SC_IRSEQ_TRAP_EN
          state_nx = ST_HALT;
`else
          retire = 1'b1;
`endif
        else state_nx = ST_EXEC;
      end
      // EXEC also forms the ld/st effective address before the memory cycle
      ST_EXEC: begin
        SC_IRSEQ_ALUSrcImm_Out = cls == CLS_ARITH && SC_IRSEQ_IR13_In;
        if (cls == CLS_BRANCH) begin
          retire             = 1'b1;
          SC_IRSEQ_PCSel_Out = SC_IRSEQ_CondTrue_In ? PCSEL_BR : PCSEL_PC4;
        end else state_nx = cls inside {CLS_LD, CLS_ST} ? ST_MEM : ST_WB;
      end
      ST_MEM: begin
        SC_IRSEQ_MemRead_Out  = cls == CLS_LD;
        SC_IRSEQ_MemWrite_Out = cls == CLS_ST;
        if (SC_IRSEQ_MemAck_In) begin
          if (cls == CLS_LD) state_nx = ST_WB;
          else retire = 1'b1;
        end
      end
      ST_WB: begin
        retire                   = 1'b1;
        SC_IRSEQ_RegWrite_OutLow = 1'b0;
        SC_IRSEQ_WBSel_Out       = cls == CLS_LD ? WBSEL_MEM : cls inside {CLS_CALL, CLS_JMPL} ? WBSEL_PC : WBSEL_ALU;
        SC_IRSEQ_PCSel_Out       = cls == CLS_CALL ? PCSEL_CALL : cls == CLS_JMPL ? PCSEL_ALU : PCSEL_PC4;
      end
      default: state_nx = state;
    endcase
    if (retire) begin
      SC_IRSEQ_PCWrite_OutLow = 1'b0;
      state_nx                = SC_IRSEQ_Start_In ? ST_FETCH : ST_IDLE;
    end
  end
  assign SC_IRSEQ_State_Out      = state;
  assign SC_IRSEQ_InstrCount_Out = count;
`ifdef SC_IRSEQ_TRAP_EN
  assign SC_IRSEQ_Error_Out = state == ST_HALT;
`else
  assign SC_IRSEQ_Error_Out = 1'b0;
`endif
endmodule

// File: tb/tb_sc_ir_sequencer.sv
// tb_sc_ir_sequencer: directed scoreboard bench for sc_ir_sequencer
module tb_sc_ir_sequencer;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [7:0]  op = 8'h00;
  logic        ir13 = 1'b0;
  logic        cond = 1'b0;
  logic        ack = 1'b0;
  logic        rd, wr, irn, pcn, rgn, imm, err;
  logic [1:0]  pcsel, wbsel;
  logic [2:0]  st;
  logic [15:0] cnt;
  logic [29:0] sb[$];
  int          tests = 0;
  int          fails = 0;
  int          ecnt = 0;

  sc_ir_sequencer #(.COUNTWIDTH(16)) dut (
    .SC_IRSEQ_CLOCK_50       (clk),
    .SC_IRSEQ_RESET_InLow    (rst_n),
    .SC_IRSEQ_Start_In       (start),
    .SC_IRSEQ_OP_In          (op),
    .SC_IRSEQ_IR13_In        (ir13),
    .SC_IRSEQ_CondTrue_In    (cond),
    .SC_IRSEQ_MemAck_In      (ack),
    .SC_IRSEQ_MemRead_Out    (rd),
    .SC_IRSEQ_MemWrite_Out   (wr),
    .SC_IRSEQ_IRWrite_OutLow (irn),
    .SC_IRSEQ_PCWrite_OutLow (pcn),
    .SC_IRSEQ_PCSel_Out      (pcsel),
    .SC_IRSEQ_RegWrite_OutLow(rgn),
    .SC_IRSEQ_WBSel_Out      (wbsel),
    .SC_IRSEQ_ALUSrcImm_Out  (imm),
    .SC_IRSEQ_State_Out      (st),
    .SC_IRSEQ_Error_Out      (err),
    .SC_IRSEQ_InstrCount_Out (cnt)
  );

  always #5 clk = ~clk;

  function automatic logic [29:0] mk(input int s, input bit r, input bit w, input bit i_n, input bit p_n,
                                     input int ps, input bit g_n, input int ws, input bit im, input bit er, input int c);
    return {3'(s), r, w, i_n, p_n, 2'(ps), g_n, 2'(ws), im, er, 16'(c)};
  endfunction

  task automatic push(input logic [29:0] e);
    sb.push_back(e);
  endtask

  task automatic chk(input string tag);
    logic [29:0] o, x;
    #1;
    o = {st, rd, wr, irn, pcn, pcsel, rgn, wbsel, imm, err, cnt};
    x = sb.pop_front();
    tests++;
    assert (o === x) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, o, x);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  initial begin
    // reset state
    #3;
    push(mk(0, 0, 0, 1, 1, 0, 1, 0, 0, 0, 0)); chk("reset");
    @(negedge clk); rst_n = 1'b1;
    start = 1'b1; op = 8'h80; ir13 = 1'b1; ack = 1'b0;
    cyc(); push(mk(1, 1, 0, 1, 1, 0, 1, 0, 0, 0, 0)); chk("fetch_wait");
    cyc(); ack = 1'b1;
    push(mk(1, 1, 0, 0, 1, 0, 1, 0, 0, 0, 0)); chk("fetch_ack");
    cyc(); push(mk(2, 0, 0, 1, 1, 0, 1, 0, 0, 0, 0)); chk("add_decode");
    cyc(); push(mk(3, 0, 0, 1, 1, 0, 1, 0, 1, 0, 0)); chk("add_exec_imm");
    cyc(); push(mk(5, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0)); chk("add_wb");
    ecnt = 1;
    // load with ack arriving on the third MEM cycle
    cyc(); op = 8'hC0;
    push(mk(1, 1, 0, 0, 1, 0, 1, 0, 0, 0, ecnt)); chk("ld_fetch");
    cyc(); ack = 1'b0;
    push(mk(2, 0, 0, 1, 1, 0, 1, 0, 0, 0, ecnt)); chk("ld_decode");
    cyc(); push(mk(3, 0, 0, 1, 1, 0, 1, 0, 0, 0, ecnt)); chk("ld_exec_noimm");
    cyc(); push(mk(4, 1, 0, 1, 1, 0, 1, 0, 0, 0, ecnt)); chk("ld_mem1");
    cyc(); push(mk(4, 1, 0, 1, 1, 0, 1, 0, 0, 0, ecnt)); chk("ld_mem2");
    cyc(); ack = 1'b1;
    push(mk(4, 1, 0, 1, 1, 0, 1, 0, 0, 0, ecnt)); chk("ld_mem3");
    cyc(); op = 8'h10; cond = 1'b1;
    push(mk(5, 0, 0, 1, 0, 0, 0, 1, 0, 0, ecnt)); chk("ld_wb");
    ecnt++;
    // taken branch; ack held high through DECODE/EXEC is ignored
    cyc(); push(mk(1, 1, 0, 0, 1, 0, 1, 0, 0, 0, ecnt)); chk("br_fetch");
    cyc(); push(mk(2, 0, 0, 1, 1, 0, 1, 0, 0, 0, ecnt)); chk("br_decode");
    cyc(); op = 8'h40;
    push(mk(3, 0, 0, 1, 0, 1, 1, 0, 0, 0, ecnt)); chk("br_taken");
    ecnt++;
    // call
    cyc(); push(mk(1, 1, 0, 0, 1, 0, 1, 0, 0, 0, ecnt)); chk("call_fetch");
    cyc(); push(mk(2, 0, 0, 1, 1, 0, 1, 0, 0, 0, ecnt)); chk("call_decode");
    cyc(); op = 8'hC4;
    push(mk(5, 0, 0, 1, 0, 2, 0, 2, 0, 0, ecnt)); chk("call_wb");
    ecnt++;
    // store; Start drops mid-instruction and takes effect at retire
    cyc(); push(mk(1, 1, 0, 0, 1, 0, 1, 0, 0, 0, ecnt)); chk("st_fetch");
    cyc(); start = 1'b0;
    push(mk(2, 0, 0, 1, 1, 0, 1, 0, 0, 0, ecnt)); chk("st_decode");
    cyc(); push(mk(3, 0, 0, 1, 1, 0, 1, 0, 0, 0, ecnt)); chk("st_exec");
    cyc(); push(mk(4, 0, 1, 1, 0, 0, 1, 0, 0, 0, ecnt)); chk("st_mem_retire");
    ecnt++;
    cyc(); push(mk(0, 0, 0, 1, 1, 0, 1, 0, 0, 0, ecnt)); chk("st_to_idle");
    // branch not taken
    start = 1'b1; op = 8'h10; cond = 1'b0;
    cyc(); cyc();
    push(mk(2, 0, 0, 1, 1, 0, 1, 0, 0, 0, ecnt)); chk("brn_decode");
    cyc(); op = 8'hFF;
    push(mk(3, 0, 0, 1, 0, 0, 1, 0, 0, 0, ecnt)); chk("br_not_taken");
    ecnt++;
    // illegal opcode
    cyc(); cyc();
`ifdef SC_IRSEQ_TRAP_EN
    push(mk(2, 0, 0, 1, 1, 0, 1, 0, 0, 0, ecnt)); chk("ill_decode_trap");
    cyc(); push(mk(6, 0, 0, 1, 1, 0, 1, 0, 0, 1, ecnt)); chk("ill_halt");
    cyc(); push(mk(6, 0, 0, 1, 1, 0, 1, 0, 0, 1, ecnt)); chk("halt_sticky");
    rst_n = 1'b0;
    ecnt = 0;
    push(mk(0, 0, 0, 1, 1, 0, 1, 0, 0, 0, 0)); chk("halt_reset");
    @(negedge clk); rst_n = 1'b1;
    cyc();
`else
    push(mk(2, 0, 0, 1, 0, 0, 1, 0, 0, 0, ecnt)); chk("ill_nop_retire");
    ecnt++;
    cyc();
`endif
    op = 8'hC0;
    push(mk(1, 1, 0, 0, 1, 0, 1, 0, 0, 0, ecnt)); chk("ld2_fetch");
    // reset asserted while a load request is pending
    cyc(); ack = 1'b0;
    cyc(); cyc();
    push(mk(4, 1, 0, 1, 1, 0, 1, 0, 0, 0, ecnt)); chk("ld2_mem");
    rst_n = 1'b0;
    push(mk(0, 0, 0, 1, 1, 0, 1, 0, 0, 0, 0)); chk("abort_reset");
    ack = 1'b1;
    cyc(); push(mk(0, 0, 0, 1, 1, 0, 1, 0, 0, 0, 0)); chk("reset_hold");
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
